// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg
//   Shared encodings for the load/store unit: access sizes, exception codes,
//   controller states and a misalignment helper.
package lsu_mem_ctrl_pkg;

   // Access size encodings (req_size_i)
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   // Exception codes (excp_code_o)
   localparam logic [1:0] EXC_NONE  = 2'b00;
   localparam logic [1:0] EXC_ALIGN = 2'b01;
   localparam logic [1:0] EXC_TMO   = 2'b10;
   localparam logic [1:0] EXC_SIZE  = 2'b11;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   // Half accesses need an even address, word accesses a 4-byte aligned one.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane.sv
// lsu_lane
//   Combinational byte-lane helper. From size, signedness and byte offset it
//   produces the byte enables, the lane-replicated write word and the
//   extracted, extended load value.
//   Ports:
//     size_i   access size          signed_i  sign-extend loads
//     off_i    byte offset          wdata_i   right-aligned store data
//     rdata_i  raw memory word      be_o      byte-lane enables
//     wdata_o  replicated store     rdata_o   extended load data
module lsu_lane
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] shifted;

   always_comb begin
      be_o    = 4'b0000;
      wdata_o = 32'h0;
      rdata_o = 32'h0;
      // Bring the addressed byte(s) down to bit 0.
      shifted = rdata_i >> {off_i, 3'b000};
      case (size_i)
         SZ_B: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
         end
         SZ_H: begin
            be_o    = off_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
         end
         SZ_W: begin
            // Word offset is always zero here, so shifted equals the raw word.
            be_o    = 4'b1111;
            wdata_o = wdata_i;
            rdata_o = shifted;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
//   Handshaked load/store unit between execute stage and data memory.
//   IDLE checks legality and latches the request, ACCESS holds the memory
//   request until mem_ready or timeout, RESP pulses done_o for one cycle.
//   Ports:
//     clk, rst (async, active-low)
//     req_*        core request (held stable while stall_o=1)
//     stall_o      core must hold PC/request
//     done_o       one-cycle completion; rdata_o/excp_o/excp_code_o valid with it
//     mem_*        memory side; mem_ready completes the access in ACCESS only
//     dbg_state_o  current controller state
//   Handshake: a request is taken when req_i=1 in IDLE; the memory access
//   completes on the first ACCESS cycle with mem_ready=1; done_o marks the
//   single cycle in which the core may consume the result and advance.
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 16,
   parameter int ALIGN_CHK   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_signed_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [31:0]       rdata_o,
   output logic              excp_o,
   output logic [1:0]        excp_code_o,
   output logic              mem_cs,
   output logic              mem_rw,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [1:0]        dbg_state_o
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   lsu_state_e        state_q, state_d;
   logic              rw_q, rw_d;
   logic [3:0]        be_q, be_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [1:0]        off_q, off_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              excp_q, excp_d;
   logic [1:0]        code_q, code_d;

   logic [1:0]  req_off, eff_off;
   logic [3:0]  st_be, ld_be;
   logic [31:0] st_wdata, ld_wdata, st_rdata, ld_rdata;
   logic        lane_unused;

   // Offset as seen by the lanes: half/word low bits forced to zero. With the
   // alignment check on, misaligned requests never reach ACCESS, so masking
   // only changes behaviour when the check is disabled.
   always_comb begin
      req_off = req_addr_i[1:0];
      case (req_size_i)
         SZ_W:    eff_off = 2'b00;
         SZ_H:    eff_off = {req_off[1], 1'b0};
         default: eff_off = req_off;
      endcase
   end

   lsu_lane u_store_lane (
      .size_i  (req_size_i),
      .signed_i(1'b0),
      .off_i   (eff_off),
      .wdata_i (req_wdata_i),
      .rdata_i (32'h0),
      .be_o    (st_be),
      .wdata_o (st_wdata),
      .rdata_o (st_rdata)
   );

   lsu_lane u_load_lane (
      .size_i  (size_q),
      .signed_i(signed_q),
      .off_i   (off_q),
      .wdata_i (32'h0),
      .rdata_i (mem_rdata),
      .be_o    (ld_be),
      .wdata_o (ld_wdata),
      .rdata_o (ld_rdata)
   );

   // Each lane instance only drives part of its outputs into the datapath.
   assign lane_unused = ^{st_rdata, ld_be, ld_wdata};

   always_comb begin
      state_d  = state_q;
      rw_d     = rw_q;
      be_d     = be_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      size_d   = size_q;
      signed_d = signed_q;
      off_d    = off_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      excp_d   = excp_q;
      code_d   = code_q;
      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               rdata_d = 32'h0;
               if (req_size_i == SZ_X) begin
                  state_d = ST_RESP;
                  excp_d  = 1'b1;
                  code_d  = EXC_SIZE;
               end else if ((ALIGN_CHK != 0) && is_misaligned(req_size_i, req_off)) begin
                  state_d = ST_RESP;
                  excp_d  = 1'b1;
                  code_d  = EXC_ALIGN;
               end else begin
                  state_d  = ST_ACCESS;
                  rw_d     = req_we_i;
                  be_d     = st_be;
                  addr_d   = {req_addr_i[ADDR_W-1:2], 2'b00};
                  wdata_d  = st_wdata;
                  size_d   = req_size_i;
                  signed_d = req_signed_i;
                  off_d    = eff_off;
                  cnt_d    = '0;
                  excp_d   = 1'b0;
                  code_d   = EXC_NONE;
               end
            end
         end
         ST_ACCESS: begin
            // Ready takes priority over a timeout in the same cycle.
            if (mem_ready) begin
               state_d = ST_RESP;
               rdata_d = rw_q ? 32'h0 : ld_rdata;
            end else if ((TIMEOUT_CYC > 0) && (cnt_q == CNT_LAST)) begin
               state_d = ST_RESP;
               excp_d  = 1'b1;
               code_d  = EXC_TMO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         rw_q     <= 1'b0;
         be_q     <= 4'b0000;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         off_q    <= 2'b00;
         cnt_q    <= '0;
         rdata_q  <= 32'h0;
         excp_q   <= 1'b0;
         code_q   <= 2'b00;
      end else begin
         state_q  <= state_d;
         rw_q     <= rw_d;
         be_q     <= be_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         off_q    <= off_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         excp_q   <= excp_d;
         code_q   <= code_d;
      end
   end

   // stall_o is gated by rst so a request held through reset cannot stall.
   assign stall_o     = rst & (((state_q == ST_IDLE) & req_i) | (state_q == ST_ACCESS));
   assign done_o      = (state_q == ST_RESP);
   assign rdata_o     = done_o ? rdata_q : 32'h0;
   assign excp_o      = done_o & excp_q;
   assign excp_code_o = done_o ? code_q : 2'b00;
   assign mem_cs      = (state_q == ST_ACCESS);
   assign mem_rw      = rw_q;
   assign mem_be      = be_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl
//   Randomized and directed bench for lsu_mem_ctrl with a transaction-level
//   reference model and a per-cycle compare process.
module tb_lsu_mem_ctrl;

   localparam int TMO = 4;

   typedef struct packed {
      logic        rw;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  cs;
      logic [31:0] rdata;
      logic        excp;
      logic [1:0]  code;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_i = 1'b0;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'b00;
   logic        req_signed_i = 1'b0;
   logic [31:0] req_addr_i = 32'h0;
   logic [31:0] req_wdata_i = 32'h0;
   logic        stall_o, done_o, excp_o;
   logic [31:0] rdata_o;
   logic [1:0]  excp_code_o;
   logic        mem_cs, mem_rw;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;
   logic [1:0]  dbg_state;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   int   cs_cnt = 0;
   int   cur_wait = 0;
   logic [3:0]  last_be;
   logic [31:0] last_wdata;

   lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TMO), .ALIGN_CHK(1)) dut (
      .clk(clk), .rst(rst),
      .req_i(req_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
      .req_signed_i(req_signed_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
      .excp_o(excp_o), .excp_code_o(excp_code_o),
      .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .dbg_state_o(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   // Reference model: what one access must produce, from the access rules.
   function automatic exp_t model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rword, input int wt);
      exp_t        e;
      int          nb;
      int          o;
      logic [63:0] mask;
      logic [31:0] v;
      e      = '0;
      e.rw   = we;
      e.addr = addr & 32'hFFFF_FFFC;
      o      = int'(addr[1:0]);
      if (size == 2'b11) begin
         e.excp = 1'b1;
         e.code = 2'b11;
      end else if ((size == 2'b01 && addr[0]) || (size == 2'b10 && o != 0)) begin
         e.excp = 1'b1;
         e.code = 2'b01;
      end else begin
         nb      = 1 << size;
         mask    = (64'd1 << (8 * nb)) - 64'd1;
         e.be    = 4'(((1 << nb) - 1) << o);
         e.wdata = (nb == 1) ? 32'(wdata[7:0]) * 32'h0101_0101 :
                   (nb == 2) ? 32'(wdata[15:0]) * 32'h0001_0001 : wdata;
         if (wt >= TMO) begin
            e.cs   = 8'(TMO);
            e.excp = 1'b1;
            e.code = 2'b10;
         end else begin
            e.cs = 8'(wt + 1);
            if (!we) begin
               v = 32'((64'(rword) >> (8 * o)) & mask);
               if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~mask[31:0];
               e.rdata = v;
            end
         end
      end
      return e;
   endfunction

   // Compare process and memory responder.
   always @(negedge clk) begin
      if (rst) begin
         if (mem_cs) begin
            cs_cnt++;
            last_be    = mem_be;
            last_wdata = mem_wdata;
            if (exp_q.size() == 0) begin
               check("cs_without_request", 32'(mem_cs), 32'd0);
            end else begin
               check("mem_rw", 32'(mem_rw), 32'(exp_q[0].rw));
               check("mem_be", 32'(mem_be), 32'(exp_q[0].be));
               check("mem_addr", mem_addr, exp_q[0].addr);
               if (exp_q[0].rw) check("mem_wdata", mem_wdata, exp_q[0].wdata);
               check("cs_len_bound", 32'(cs_cnt <= int'(exp_q[0].cs)), 32'd1);
            end
         end
         if (done_o) begin
            if (exp_q.size() == 0) begin
               check("done_without_request", 32'(done_o), 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("rdata", rdata_o, e.rdata);
               check("excp", 32'(excp_o), 32'(e.excp));
               check("excp_code", 32'(excp_code_o), 32'(e.code));
               check("cs_cycles", 32'(cs_cnt), 32'(e.cs));
            end
            cs_cnt = 0;
         end else begin
            check("idle_rdata_zero", rdata_o, 32'h0);
            check("idle_excp_zero", 32'(excp_o), 32'd0);
         end
      end
      // Random noise on mem_ready outside ACCESS must be ignored.
      mem_ready = mem_cs ? (cs_cnt == cur_wait + 1) : 1'($urandom_range(0, 1));
   end

   task automatic run_access(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rword, input int wt, input logic pin_en,
                             input logic [31:0] pin_rdata, input logic [1:0] pin_code);
      exp_t e;
      int   lat;
      int   n;
      logic got;
      e   = model(we, size, sgn, addr, wdata, rword, wt);
      lat = 2 + int'(e.cs);
      @(posedge clk);
      #1;
      req_i        = 1'b1;
      req_we_i     = we;
      req_size_i   = size;
      req_signed_i = sgn;
      req_addr_i   = addr;
      req_wdata_i  = wdata;
      mem_rdata    = rword;
      cur_wait     = wt;
      exp_q.push_back(e);
      got = 1'b0;
      n   = 0;
      while (!got && n < lat + 3) begin
         @(negedge clk);
         n++;
         check("stall", 32'(stall_o), 32'(n < lat));
         if (done_o) begin
            got = 1'b1;
            check("latency", 32'(n), 32'(lat));
            if (pin_en) begin
               check("pin_rdata", rdata_o, pin_rdata);
               check("pin_code", 32'(excp_code_o), 32'(pin_code));
            end
         end
      end
      if (!got) check("done_timeout", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      req_i = 1'b0;
   endtask

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog got=expired exp=finished");
      n_errors++;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic        we, sgn;
      logic [1:0]  sz;
      logic [31:0] a;
      int          r, wt;

      // Reset state
      #23;
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_rdata", rdata_o, 32'h0);
      check("rst_excp", 32'({excp_o, excp_code_o}), 32'd0);
      check("rst_mem_cs", 32'(mem_cs), 32'd0);
      check("rst_mem_ctl", 32'({mem_rw, mem_be}), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Directed accesses with literal expectations
      run_access(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 1'b1, 32'h0, 2'b00);
      check("pin_word_store_be", 32'(last_be), 32'hF);
      check("pin_word_store_wdata", last_wdata, 32'hDEAD_BEEF);
      run_access(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FF_0000, 0, 1'b1, 32'hFFFF_FF80, 2'b00);
      run_access(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FF_0000, 1, 1'b1, 32'h0000_0080, 2'b00);
      run_access(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_ABCD, 32'h0, 0, 1'b1, 32'h0, 2'b00);
      check("pin_half_store_be", 32'(last_be), 32'hC);
      check("pin_half_store_wdata", last_wdata, 32'hABCD_ABCD);
      run_access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h8001_0000, 2, 1'b1, 32'hFFFF_8001, 2'b00);
      run_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h8001_0000, 0, 1'b1, 32'h0000_8001, 2'b00);
      run_access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h1234_5678, 0, 1'b1, 32'h0, 2'b01);
      run_access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 0, 1'b1, 32'h0, 2'b11);
      run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 100, 1'b1, 32'h0, 2'b10);
      run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 3, 1'b1, 32'h1234_5678, 2'b00);

      // Reset in the second ACCESS cycle
      exp_q.push_back(model(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0, 100));
      @(posedge clk);
      #1;
      req_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h80;
      cur_wait = 100;
      repeat (3) @(negedge clk);
      check("pre_rst_cs", 32'(mem_cs), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("rst_drop_cs", 32'(mem_cs), 32'd0);
      check("rst_drop_stall", 32'(stall_o), 32'd0);
      check("rst_drop_done", 32'(done_o), 32'd0);
      exp_q.delete();
      cs_cnt = 0;
      req_i  = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rst_no_done", 32'(done_o), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_access(1'b0, 2'b00, 1'b1, 32'h81, 32'h0, 32'h0000_F000, 1, 1'b1, 32'hFFFF_FFF0, 2'b00);

      // Randomized accesses
      for (int i = 0; i < 60; i++) begin
         we  = 1'($urandom_range(0, 1));
         sgn = 1'($urandom_range(0, 1));
         r   = $urandom_range(0, 9);
         sz  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         a   = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
         end
         wt = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
         run_access(we, sz, sgn, a, $urandom, $urandom, wt, 1'b0, 32'h0, 2'b00);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised load/store unit between the core's execute stage and data memory.
- Replaces the fixed single-cycle mem_cs/mem_rw path with a handshaked, multi-cycle access.
- Adds byte/half/word sizes, byte enables and sign/zero extension.
- Adds a misalignment check and a ready-timeout; stalls the core until each access completes.

Parameters:
- ADDR_W, 32: request and memory address width.
- TIMEOUT_CYC, 16: maximum cycles to wait for mem_ready before raising a timeout exception. 0 disables the timeout.
- ALIGN_CHK, 1: 1 flags misaligned half/word accesses; 0 forces addr[1:0] (word) or addr[0] (half) to zero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- req_i  in  1  core requests an access; held stable while stall_o=1.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- stall_o  out  1  core must hold the PC and request.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load data, valid with done_o.
- excp_o  out  1  exception flag, valid with done_o.
- excp_code_o  out  2  01 misaligned, 10 timeout, 11 illegal size.
- mem_cs  out  1  memory chip select.
- mem_rw  out  1  1 = write.
- mem_be  out  4  byte-lane enables.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits = 0.
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  read word.
- mem_ready  in  1  memory completes the access this cycle.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs and internal registers 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On req_i=1, check legality. Size 11 → RESP with code 11. Misaligned (half with addr[0]=1, or word with addr[1:0]≠0) and ALIGN_CHK=1 → RESP with code 01. In both cases memory is never touched.
  - Otherwise latch the request, register the mem_* outputs, clear the timeout counter and go to ACCESS.
- ACCESS:
  - mem_cs=1; mem_rw/mem_be/mem_addr/mem_wdata held constant.
  - mem_ready=1 → latch extended read data, go to RESP.
  - Otherwise the counter increments. When counter = TIMEOUT_CYC-1 and no ready (TIMEOUT_CYC>0), go to RESP with code 10.
  - mem_ready and timeout in the same cycle: ready wins, no exception.
- RESP:
  - done_o=1; excp_o/excp_code_o valid; mem_cs=0.
  - rdata_o = load data on a successful load, otherwise 0.
  - Always returns to IDLE. req_i in this cycle still belongs to the finished instruction and is ignored.
- stall_o = (IDLE & req_i) | ACCESS. It is 0 in RESP so the core advances.
- Latency: minimum 3 cycles from req_i to done_o, i.e. accept, ACCESS with immediate ready, RESP. Each wait state adds one cycle. Exception responses take 2 cycles.
- Byte enables, with o = addr[1:0]:
  - byte: 1<<o.
  - half: 0011 if o[1]=0, else 1100.
  - word: 1111.
- mem_wdata:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extract: mem_rdata >> (8*o), truncated to the access size, then sign- or zero-extended to 32 bits. req_signed_i is ignored for word loads.
- mem_ready outside ACCESS is ignored.
- Reset mid-ACCESS drops mem_cs immediately and produces no done_o.

Decomposition:
- defines.vh gains:
  - size encodings: `SZ_B, `SZ_H, `SZ_W;
  - exception codes: `EXC_NONE, `EXC_ALIGN, `EXC_TMO, `EXC_SIZE;
  - state encodings.
- One combinational sub-module, lsu_lane: computes mem_be, mem_wdata replication and load extract/extension from size, signed and offset. It is instantiated once for store-lane generation and once for load extraction.

Test Plan:
- Word store, addr 0x104, wdata 0xDEADBEEF, mem_ready tied 1 → mem_cs=1 for 1 cycle with be=1111 and mem_addr=0x104; done_o on cycle 3; stall_o high for cycles 1–2.
- Signed byte load, addr 0x203, mem_rdata 0x80FF_0000 → rdata_o=0xFFFFFF80. The same access unsigned → 0x00000080.
- Half store, addr 0x12, wdata 0x0000ABCD → be=1100, mem_wdata=0xABCDABCD. Half load of 0x8001 at offset 2 → 0xFFFF8001 (signed), 0x00008001 (unsigned).
- Word load at addr 0x102 with ALIGN_CHK=1 → mem_cs never asserts; done_o on cycle 2 with excp_code_o=01 and rdata_o=0. Size 11 → code 11.
- mem_ready held 0 with TIMEOUT_CYC=4 → mem_cs high exactly 4 cycles, then done_o with code 10. mem_ready asserted in the 4th cycle → success, no exception.
- rst driven low during the 2nd ACCESS cycle → mem_cs/stall_o drop to 0 immediately and no done_o. After release, a new load completes normally.
